sram_dp_be: RTL and testbench

- Parametrised dual-port, byte-enable, synchronous-write SRAM used as on-chip instruction/data memory for the SoC core and its benches.
- Port A serves the core instruction interface and port B the data interface. Both use the existing en/wen/addr/wdata/rdata signalling.
- Successor to the fixed 1024x32, zero-latency memory model. Adds configurable width, depth and read latency, read-during-write mode, a same-word write collision rule, out-of-range detection and read-valid strobes.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_rd_pipe.sv | 57 +++++
 rtl/sram_dp_be.sv | 97 +++++++++
 tb/tb_sram_dp_be.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the dual-port byte-enable SRAM.
package sram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // Address bits at or above 'lo' must be zero for an in-range access.
  function automatic logic [63:0] oor_mask(input int lo);
    return ~((64'd1 << lo) - 64'd1);
  endfunction

  function automatic logic [7:0] lane_merge(input logic [7:0] stored, input logic [7:0] fresh,
                                            input logic take_fresh);
    return take_fresh ? fresh : stored;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - RD_LAT-deep read return pipeline with hold-last-value output.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] cmp_data,
  input  logic              cmp_err,
  input  logic              cmp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err
);

  if (RD_LAT == 0) begin : g_comb
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clock) begin
      if (!reset) hold_q <= '0;
      else if (cmp_valid) hold_q <= cmp_data;
    end

    assign rdata  = cmp_valid ? cmp_data : hold_q;
    assign rvalid = cmp_valid;
    assign err    = cmp_valid & cmp_err;
  end else begin : g_pipe
    logic [DATA_W-1:0] d_q [RD_LAT];
    logic [RD_LAT-1:0] v_q;
    logic [RD_LAT-1:0] e_q;

    // Data stages only advance on valid, so the last stage keeps the last returned word.
    always_ff @(posedge clock) begin
      if (!reset) begin
        for (int k = 0; k < RD_LAT; k++) d_q[k] <= '0;
        v_q <= '0;
        e_q <= '0;
      end else begin
        v_q[0] <= cmp_valid;
        e_q[0] <= cmp_valid & cmp_err;
        if (cmp_valid) d_q[0] <= cmp_data;
        for (int k = 1; k < RD_LAT; k++) begin
          v_q[k] <= v_q[k-1];
          e_q[k] <= e_q[k-1];
          if (v_q[k-1]) d_q[k] <= d_q[k-1];
        end
      end
    end

    assign rdata  = d_q[RD_LAT-1];
    assign rvalid = v_q[RD_LAT-1];
    assign err    = e_q[RD_LAT-1];
  end

endmodule

// File: rtl/sram_dp_be.sv
// rtl/sram_dp_be.sv - dual-port byte-enable SRAM with collision, read-during-write and range checks.
module sram_dp_be
  import sram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_en,
  input  logic [DATA_W/8-1:0] a_wen,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  output logic                a_err,
  input  logic                b_en,
  input  logic [DATA_W/8-1:0] b_wen,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                b_err
);

  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = idx_w(DEPTH);
  localparam logic [63:0] OOR_MASK = oor_mask(BW + IW);
  localparam rdw_mode_e MODE = (RDW_MODE != 0) ? WRITE_FIRST : READ_FIRST;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0]     a_idx, b_idx;
  logic              a_oor, b_oor, a_act, b_act, same_idx;
  logic [NB-1:0]     a_we, b_we;
  logic [DATA_W-1:0] a_word, b_word, a_cmp, b_cmp;

  assign a_idx    = a_addr[BW+IW-1:BW];
  assign b_idx    = b_addr[BW+IW-1:BW];
  assign a_oor    = |(a_addr & OOR_MASK[ADDR_W-1:0]);
  assign b_oor    = |(b_addr & OOR_MASK[ADDR_W-1:0]);
  assign a_act    = a_en & reset;
  assign b_act    = b_en & reset;
  assign a_we     = (a_act && !a_oor) ? a_wen : '0;
  assign b_we     = (b_act && !b_oor) ? b_wen : '0;
  assign same_idx = (a_idx == b_idx);
  assign a_word   = mem[a_idx];
  assign b_word   = mem[b_idx];

  // Port B is applied last so it owns any lane both ports write in the same word.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      if (b_we[i]) mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
    end
  end

  always_comb begin
    a_cmp = '0;
    b_cmp = '0;
    for (int i = 0; i < NB; i++) begin
      a_cmp[8*i +: 8] = lane_merge(a_word[8*i +: 8], b_wdata[8*i +: 8],
                                   MODE == WRITE_FIRST && b_we[i] && same_idx);
      b_cmp[8*i +: 8] = lane_merge(b_word[8*i +: 8], a_wdata[8*i +: 8],
                                   MODE == WRITE_FIRST && a_we[i] && same_idx);
      if (a_wen[i] || a_oor) a_cmp[8*i +: 8] = 8'h00;
      if (b_wen[i] || b_oor) b_cmp[8*i +: 8] = 8'h00;
    end
  end

  sram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_a_pipe (
    .clock     (clock),
    .reset     (reset),
    .cmp_data  (a_cmp),
    .cmp_err   (a_oor),
    .cmp_valid (a_act),
    .rdata     (a_rdata),
    .rvalid    (a_rvalid),
    .err       (a_err)
  );

  sram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_b_pipe (
    .clock     (clock),
    .reset     (reset),
    .cmp_data  (b_cmp),
    .cmp_err   (b_oor),
    .cmp_valid (b_act),
    .rdata     (b_rdata),
    .rvalid    (b_rvalid),
    .err       (b_err)
  );

endmodule

// File: tb/tb_sram_dp_be.sv
// tb/tb_sram_dp_be.sv - directed bench; four instances (lat0, lat1 read-first, lat1 write-first, lat3) share stimulus.
module tb_sram_dp_be;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        a_en, b_en;
  logic [3:0]  a_wen, b_wen;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [31:0] a_rdata [4];
  logic [31:0] b_rdata [4];
  logic        a_rvalid [4];
  logic        a_err [4];
  logic        b_rvalid [4];
  logic        b_err [4];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_dp_be #(
      .DATA_W   (32),
      .DEPTH    (1024),
      .ADDR_W   (32),
      .RD_LAT   (g == 0 ? 0 : (g == 3 ? 3 : 1)),
      .RDW_MODE (g == 2 ? 1 : 0)
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .a_en     (a_en),
      .a_wen    (a_wen),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_rdata  (a_rdata[g]),
      .a_rvalid (a_rvalid[g]),
      .a_err    (a_err[g]),
      .b_en     (b_en),
      .b_wen    (b_wen),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_rdata  (b_rdata[g]),
      .b_rvalid (b_rvalid[g]),
      .b_err    (b_err[g])
    );
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    a_en = 1'b1; a_wen = be; a_addr = addr; a_wdata = data;
  endtask

  task automatic wr_b(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    b_en = 1'b1; b_wen = be; b_addr = addr; b_wdata = data;
  endtask

  task automatic rd_a(input logic [31:0] addr);
    a_en = 1'b1; a_wen = 4'h0; a_addr = addr; a_wdata = 32'h0;
  endtask

  task automatic rd_b(input logic [31:0] addr);
    b_en = 1'b1; b_wen = 4'h0; b_addr = addr; b_wdata = 32'h0;
  endtask

  task automatic idle_a();
    a_en = 1'b0; a_wen = 4'h0;
  endtask

  task automatic idle_b();
    b_en = 1'b0; b_wen = 4'h0;
  endtask

  initial begin
    a_addr = 32'h0; b_addr = 32'h0; a_wdata = 32'h0; b_wdata = 32'h0;
    idle_a(); idle_b();
    tick(); tick();
    chk("rst_a_rdata",  a_rdata[1], 32'h0);
    chk("rst_a_rvalid", 32'(a_rvalid[1]), 32'h0);
    chk("rst_b_err",    32'(b_err[3]), 32'h0);
    chk("rst_b_rvalid", 32'(b_rvalid[3]), 32'h0);
    reset = 1'b1;

    // Preload words 0x0 and 0x4, then basic write/read at 0x8
    wr_a(32'h0, 4'hF, 32'h0BADF00D); wr_b(32'h4, 4'hF, 32'h44444444); tick();
    wr_a(32'h8, 4'hF, 32'h4F261137); idle_b(); tick();
    chk("wr_rvalid",     32'(a_rvalid[1]), 32'h1);
    chk("wr_rdata_zero", a_rdata[1], 32'h0);
    rd_a(32'h8); tick();
    chk("rd_data",   a_rdata[1], 32'h4F261137);
    chk("rd_rvalid", 32'(a_rvalid[1]), 32'h1);
    chk("rd_err",    32'(a_err[1]), 32'h0);
    idle_a(); tick();
    chk("idle_rvalid", 32'(a_rvalid[1]), 32'h0);
    chk("idle_hold",   a_rdata[1], 32'h4F261137);

    // Byte merge and written-lane zeroing
    wr_a(32'h10, 4'hF, 32'hAABBCCDD); tick();
    idle_a(); wr_b(32'h10, 4'b0011, 32'h11223344); tick();
    chk("merge_same_cycle", b_rdata[1], 32'hAABB0000);
    rd_b(32'h10); tick();
    chk("merge_after", b_rdata[1], 32'hAABB3344);
    idle_b();

    // Write collision on the same word
    wr_a(32'h20, 4'hF, 32'h11111111); wr_b(32'h20, 4'b1100, 32'h22220000); tick();
    chk("coll_a_zero", a_rdata[1], 32'h0);
    chk("coll_wf_b",   b_rdata[2], 32'h00001111);
    rd_a(32'h20); idle_b(); tick();
    chk("coll_rf", a_rdata[1], 32'h22221111);
    chk("coll_wf", a_rdata[2], 32'h22221111);

    // Cross-port read-during-write
    wr_a(32'h30, 4'hF, 32'h5); tick();
    rd_a(32'h30); wr_b(32'h30, 4'hF, 32'h9); #1;
    chk("lat0_rdw", a_rdata[0], 32'h5);
    tick();
    chk("rdw_read_first",  a_rdata[1], 32'h5);
    chk("rdw_write_first", a_rdata[2], 32'h9);
    idle_b();

    // Zero-latency read follows the address within one cycle
    rd_a(32'h8); #1;
    chk("lat0_a8",     a_rdata[0], 32'h4F261137);
    chk("lat0_rvalid", 32'(a_rvalid[0]), 32'h1);
    a_addr = 32'h10; #1;
    chk("lat0_a10", a_rdata[0], 32'hAABB3344);
    idle_a(); #1;
    chk("lat0_idle_rvalid", 32'(a_rvalid[0]), 32'h0);
    chk("lat0_hold",        a_rdata[0], 32'h5);
    tick();

    // Out of range: 0x1000 aliases word 0 but must not touch it
    wr_a(32'h1000, 4'hF, 32'hDEAD); tick();
    chk("oor_wr_err",    32'(a_err[1]), 32'h1);
    chk("oor_wr_rvalid", 32'(a_rvalid[1]), 32'h1);
    chk("oor_wr_rdata",  a_rdata[1], 32'h0);
    rd_a(32'h0); tick();
    chk("oor_word0",     a_rdata[1], 32'h0BADF00D);
    chk("oor_word0_err", 32'(a_err[1]), 32'h0);
    rd_a(32'h1000); tick();
    chk("oor_rd_rdata", a_rdata[1], 32'h0);
    chk("oor_rd_err",   32'(a_err[1]), 32'h1);
    idle_a(); tick();
    chk("oor_idle_err", 32'(a_err[1]), 32'h0);

    // Three-cycle latency, back-to-back reads
    tick(); tick(); tick();
    chk("lat3_quiet", 32'(a_rvalid[3]), 32'h0);
    rd_a(32'h0); tick();
    chk("lat3_c1", 32'(a_rvalid[3]), 32'h0);
    rd_a(32'h4); tick();
    chk("lat3_c2", 32'(a_rvalid[3]), 32'h0);
    rd_a(32'h8); tick();
    chk("lat3_v1",   32'(a_rvalid[3]), 32'h1);
    chk("lat3_d1",   a_rdata[3], 32'h0BADF00D);
    idle_a(); tick();
    chk("lat3_v2",   32'(a_rvalid[3]), 32'h1);
    chk("lat3_d2",   a_rdata[3], 32'h44444444);
    tick();
    chk("lat3_v3",   32'(a_rvalid[3]), 32'h1);
    chk("lat3_d3",   a_rdata[3], 32'h4F261137);
    tick();
    chk("lat3_end",  32'(a_rvalid[3]), 32'h0);
    chk("lat3_hold", a_rdata[3], 32'h4F261137);

    // Reset with reads in flight; the write presented during reset is discarded
    rd_a(32'h0); tick();
    rd_a(32'h4); tick();
    reset = 1'b0; wr_a(32'h4, 4'hF, 32'hFFFFFFFF); tick();
    chk("rst3_rvalid",  32'(a_rvalid[3]), 32'h0);
    chk("rst3_rdata",   a_rdata[3], 32'h0);
    chk("rst3_err",     32'(a_err[3]), 32'h0);
    chk("rst1_rdata",   a_rdata[1], 32'h0);
    reset = 1'b1; idle_a();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst3_drop", 32'(a_rvalid[3]), 32'h0);
    end
    rd_a(32'h4); tick();
    idle_a(); tick(); tick();
    chk("rst3_mem_rvalid", 32'(a_rvalid[3]), 32'h1);
    chk("rst3_mem_intact", a_rdata[3], 32'h44444444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
